// File: rtl/generador_sincronia.sv
// generador_sincronia: VGA raster timing generator plus frame-synchronous
// colour configuration registers. The raster geometry and the clock divider
// are parameters. The defaults give 640x480@60 Hz from a 50 MHz clock.
// Every output comes straight from a flop. The flops are loaded from the
// next-state values, so each output matches the pixel_x/pixel_y shown in
// the same cycle.
module generador_sincronia #(
  parameter int unsigned DIV    = 2,
  parameter int unsigned H_VIS  = 640,
  parameter int unsigned H_FP   = 16,
  parameter int unsigned H_SYNC = 96,
  parameter int unsigned H_BP   = 48,
  parameter int unsigned V_VIS  = 480,
  parameter int unsigned V_FP   = 10,
  parameter int unsigned V_SYNC = 2,
  parameter int unsigned V_BP   = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cargar,
  input  logic [2:0] ColorP_in,
  input  logic [2:0] ColorL_in,
  input  logic [7:0] ton_in,
  output logic       pix_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       hsync,
  output logic       vsync,
  output logic       blank,
  output logic       frame_start,
  output logic [2:0] ColorP,
  output logic [2:0] ColorL,
  output logic [7:0] ton,
  output logic       pendiente
);

  // Divider width. It is at least one bit, so a DIV of 1 still elaborates.
  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);

  localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] X_VIS    = 10'(H_VIS);
  localparam logic [9:0] X_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] Y_VIS    = 10'(V_VIS);
  localparam logic [9:0] Y_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC - 1);

  // Colour configuration after reset: black background, white text,
  // full tone.
  localparam logic [2:0] COLORP_RST = 3'b000;
  localparam logic [2:0] COLORL_RST = 3'b111;
  localparam logic [7:0] TON_RST    = 8'hFF;

  // Raster state.
  logic [DW-1:0] div_q, div_d;
  logic [9:0]    x_q, x_d;
  logic [9:0]    y_q, y_d;
  logic          pix_tick_q, pix_tick_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          blank_q, blank_d;
  logic          frame_start_q, frame_start_d;

  // Configuration state: applied registers plus a shadow copy that waits
  // for the frame boundary.
  logic [2:0] colorp_q, colorp_d;
  logic [2:0] colorl_q, colorl_d;
  logic [7:0] ton_q, ton_d;
  logic [2:0] sh_colorp_q, sh_colorp_d;
  logic [2:0] sh_colorl_q, sh_colorl_d;
  logic [7:0] sh_ton_q, sh_ton_d;
  logic       pend_q, pend_d;

  // Next divider value and next pixel position.
  // The pixel position advances only on the edge that closes a pix_tick
  // cycle.
  always_comb begin
    div_d = div_q;
    x_d   = x_q;
    y_d   = y_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIV_ONE;
    end
    if (pix_tick_q) begin
      if (x_q == X_LAST) begin
        x_d = 10'd0;
        if (y_q == Y_LAST) begin
          y_d = 10'd0;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
        y_d = y_q;
      end
    end else begin
      x_d = x_q;
      y_d = y_q;
    end
  end

  // Decode the sync, blank and frame strobes from the next position.
  // The registered copies then line up with the registered coordinates.
  always_comb begin
    pix_tick_d    = (div_d == DIV_LAST);
    blank_d       = (x_d >= X_VIS) | (y_d >= Y_VIS);
    hsync_d       = ~((x_d >= HS_START) & (x_d <= HS_END));
    vsync_d       = ~((y_d >= VS_START) & (y_d <= VS_END));
    frame_start_d = pix_tick_d & (x_d == X_LAST) & (y_d == Y_LAST);
  end

  // Next configuration state. At a frame boundary any pending shadow is
  // applied first. A capture in the same cycle then refills the shadow and
  // keeps the request pending.
  always_comb begin
    colorp_d    = colorp_q;
    colorl_d    = colorl_q;
    ton_d       = ton_q;
    sh_colorp_d = sh_colorp_q;
    sh_colorl_d = sh_colorl_q;
    sh_ton_d    = sh_ton_q;
    pend_d      = pend_q;
    if (frame_start_q && pend_q) begin
      colorp_d = sh_colorp_q;
      colorl_d = sh_colorl_q;
      ton_d    = sh_ton_q;
    end else begin
      colorp_d = colorp_q;
      colorl_d = colorl_q;
      ton_d    = ton_q;
    end
    if (cargar) begin
      sh_colorp_d = ColorP_in;
      sh_colorl_d = ColorL_in;
      sh_ton_d    = ton_in;
      pend_d      = 1'b1;
    end else if (frame_start_q) begin
      pend_d      = 1'b0;
    end else begin
      pend_d      = pend_q;
    end
  end

  // Raster registers with synchronous reset to pixel (0,0).
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q         <= '0;
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      pix_tick_q    <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      blank_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      x_q           <= x_d;
      y_q           <= y_d;
      pix_tick_q    <= pix_tick_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_q       <= blank_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Configuration registers. Reset discards any pending request.
  always_ff @(posedge clk) begin
    if (reset) begin
      colorp_q    <= COLORP_RST;
      colorl_q    <= COLORL_RST;
      ton_q       <= TON_RST;
      sh_colorp_q <= COLORP_RST;
      sh_colorl_q <= COLORL_RST;
      sh_ton_q    <= TON_RST;
      pend_q      <= 1'b0;
    end else begin
      colorp_q    <= colorp_d;
      colorl_q    <= colorl_d;
      ton_q       <= ton_d;
      sh_colorp_q <= sh_colorp_d;
      sh_colorl_q <= sh_colorl_d;
      sh_ton_q    <= sh_ton_d;
      pend_q      <= pend_d;
    end
  end

  assign pix_tick    = pix_tick_q;
  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank       = blank_q;
  assign frame_start = frame_start_q;
  assign ColorP      = colorp_q;
  assign ColorL      = colorl_q;
  assign ton         = ton_q;
  assign pendiente   = pend_q;

endmodule

// File: tb/tb_generador_sincronia.sv
// Testbench for generador_sincronia. It runs a reduced raster so that whole
// frames fit in a short run:
//   horizontal 16/2/4/2  = 24 pixels per line
//   vertical   10/2/2/3  = 17 lines per frame
// The divider is 2, so one frame is 24*17*2 = 816 clk.
// The reference model derives the raster from the clk count since reset.
// The colour configuration follows the load/apply rules at event level.
module tb_generador_sincronia;

  localparam int DIV = 2;
  localparam int HV = 16, HF = 2, HS = 4, HB = 2;
  localparam int VV = 10, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;

  logic       clk = 1'b0;
  logic       reset;
  logic       cargar;
  logic [2:0] ColorP_in, ColorL_in;
  logic [7:0] ton_in;
  logic       pix_tick, hsync, vsync, blank, frame_start, pendiente;
  logic [9:0] pixel_x, pixel_y;
  logic [2:0] ColorP, ColorL;
  logic [7:0] ton;

  always #5 clk = ~clk;

  generador_sincronia #(
    .DIV(DIV), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .reset(reset), .cargar(cargar),
    .ColorP_in(ColorP_in), .ColorL_in(ColorL_in), .ton_in(ton_in),
    .pix_tick(pix_tick), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .hsync(hsync), .vsync(vsync), .blank(blank), .frame_start(frame_start),
    .ColorP(ColorP), .ColorL(ColorL), .ton(ton), .pendiente(pendiente)
  );

  int checks = 0;
  int errors = 0;

  // Count one comparison and report it if it fails.
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_n = 0;
  bit         m_valid = 1'b0;
  logic [2:0] m_cp, m_cl, m_scp, m_scl;
  logic [7:0] m_ton, m_ston;
  bit         m_pend;
  int         m_p, m_div, m_x, m_y;
  bit         m_tick, m_fs, m_blank, m_hs, m_vs;

  // The raster is a pure function of the clk count since reset.
  always_comb begin
    m_p     = m_n / DIV;
    m_div   = m_n % DIV;
    m_x     = m_p % HT;
    m_y     = (m_p / HT) % VT;
    m_tick  = (m_div == DIV - 1);
    m_fs    = m_tick && (m_x == HT - 1) && (m_y == VT - 1);
    m_blank = (m_x >= HV) || (m_y >= VV);
    m_hs    = !((m_x >= HV + HF) && (m_x < HV + HF + HS));
    m_vs    = !((m_y >= VV + VF) && (m_y < VV + VF + VS));
  end

  // Configuration events: apply at the frame boundary, capture on cargar.
  always @(posedge clk) begin
    if (reset) begin
      m_n     <= 0;
      m_valid <= 1'b1;
      m_cp    <= 3'b000; m_cl  <= 3'b111; m_ton  <= 8'hFF;
      m_scp   <= 3'b000; m_scl <= 3'b111; m_ston <= 8'hFF;
      m_pend  <= 1'b0;
    end else if (m_valid) begin
      if (m_fs && m_pend) begin
        m_cp <= m_scp; m_cl <= m_scl; m_ton <= m_ston;
      end
      if (cargar) begin
        m_scp <= ColorP_in; m_scl <= ColorL_in; m_ston <= ton_in;
        m_pend <= 1'b1;
      end else if (m_fs) begin
        m_pend <= 1'b0;
      end
      m_n <= m_n + 1;
    end
  end

  // Compare every output against the model on every cycle after reset.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("cycle", {24'd0, pix_tick, pixel_x, pixel_y, hsync, vsync, blank,
                    frame_start, ColorP, ColorL, ton, pendiente},
          {24'd0, m_tick, 10'(m_x), 10'(m_y), m_hs, m_vs, m_blank,
           m_fs, m_cp, m_cl, m_ton, m_pend});
    end
  end

  // ---------------- directed stimulus ----------------
  // Wait until the model is on the first clk of pixel (x,y).
  task automatic wait_at(input int x, input int y);
    int k = 0;
    while (!(m_x == x && m_y == y && m_div == 0) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) begin
      errors++;
      $display("FAIL wait_at(%0d,%0d) timed out", x, y);
    end
  endtask

  // Wait until the model shows the frame_start cycle.
  task automatic wait_fs();
    int k = 0;
    while (!m_fs && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) begin
      errors++;
      $display("FAIL wait_fs timed out");
    end
  endtask

  // Issue a one-clk cargar request with the given values.
  task automatic load(input logic [2:0] cp, input logic [2:0] cl, input logic [7:0] t);
    ColorP_in = cp; ColorL_in = cl; ton_in = t; cargar = 1'b1;
    @(negedge clk);
    cargar = 1'b0;
  endtask

  int hs_low, vs_low, blank0, fs_cnt, fs_k, fall1, fall2;
  logic hs_prev;

  initial begin
    reset = 1'b1; cargar = 1'b0;
    ColorP_in = 3'b000; ColorL_in = 3'b000; ton_in = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    // Reset state.
    chk("rst_x", pixel_x, 10'd0);
    chk("rst_y", pixel_y, 10'd0);
    chk("rst_tick", pix_tick, 1'b0);
    chk("rst_hsync", hsync, 1'b1);
    chk("rst_vsync", vsync, 1'b1);
    chk("rst_blank", blank, 1'b0);
    chk("rst_fs", frame_start, 1'b0);
    chk("rst_pend", pendiente, 1'b0);
    chk("rst_colors", {ColorP, ColorL, ton}, {3'b000, 3'b111, 8'hFF});

    // Measure one whole frame, clk by clk.
    hs_low = 0; vs_low = 0; blank0 = 0; fs_cnt = 0; fs_k = -1;
    fall1 = -1; fall2 = -1; hs_prev = 1'b1;
    for (int k = 1; k <= HT * VT * DIV; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("first_tick", pix_tick, 1'b1);
      end
      if (k <= HT * DIV && !hsync) hs_low++;
      if (hs_prev && !hsync) begin
        if (fall1 < 0) fall1 = k;
        else if (fall2 < 0) fall2 = k;
      end
      hs_prev = hsync;
      if (!vsync) vs_low++;
      if (!blank) blank0++;
      if (frame_start) begin
        fs_cnt++;
        fs_k = k;
      end
    end
    chk("hsync_low_clks", hs_low, 8);
    chk("hsync_first_fall", fall1, 36);
    chk("hsync_period", fall2 - fall1, 48);
    chk("vsync_low_clks", vs_low, 96);
    chk("visible_clks", blank0, 320);
    chk("fs_count", fs_cnt, 1);
    chk("fs_position", fs_k, 815);

    // Blank and sync edges.
    wait_at(15, 9);  chk("blank_15_9", blank, 1'b0);
    wait_at(16, 9);  chk("blank_16_9", blank, 1'b1);
    wait_at(18, 9);  chk("hsync_18", hsync, 1'b0);
    wait_at(22, 9);  chk("hsync_22", hsync, 1'b1);
    wait_at(0, 10);  chk("blank_0_10", blank, 1'b1);
    wait_at(0, 12);  chk("vsync_12", vsync, 1'b0);
    wait_at(0, 14);  chk("vsync_14", vsync, 1'b1);

    // Two loads before the boundary: the later one wins.
    wait_at(5, 3);
    load(3'b101, 3'b010, 8'hA5);
    chk("s1_pend", pendiente, 1'b1);
    chk("s1_hold", {ColorP, ColorL, ton}, {3'b000, 3'b111, 8'hFF});
    wait_at(5, 6);
    load(3'b101, 3'b010, 8'h3C);
    chk("s1_hold2", ton, 8'hFF);
    wait_fs();
    chk("wrap_fs", frame_start, 1'b1);
    chk("wrap_tick", pix_tick, 1'b1);
    chk("wrap_xy", {pixel_x, pixel_y}, {10'd23, 10'd16});
    chk("wrap_pend", pendiente, 1'b1);
    @(negedge clk);
    chk("s1_xy", {pixel_x, pixel_y}, {10'd0, 10'd0});
    chk("s1_vsync_blank", {vsync, blank}, {1'b1, 1'b0});
    chk("s1_applied", {ColorP, ColorL, ton}, {3'b101, 3'b010, 8'h3C});
    chk("s1_pend_clr", pendiente, 1'b0);

    // cargar on the frame_start cycle while 0x11 is pending.
    wait_at(4, 2);
    load(3'b011, 3'b100, 8'h11);
    wait_fs();
    load(3'b110, 3'b001, 8'h22);
    chk("s2_applied", {ColorP, ColorL, ton}, {3'b011, 3'b100, 8'h11});
    chk("s2_pend", pendiente, 1'b1);
    wait_at(3, 3);
    chk("s2_mid", {ton, pendiente}, {8'h11, 1'b1});
    wait_fs();
    @(negedge clk);
    chk("s2_next", {ColorP, ColorL, ton}, {3'b110, 3'b001, 8'h22});
    chk("s2_pend_clr", pendiente, 1'b0);

    // A boundary with nothing pending leaves the colours alone.
    wait_fs();
    @(negedge clk);
    chk("hold_ton", {ton, pendiente}, {8'h22, 1'b0});

    // Reset mid-frame with a pending load.
    wait_at(2, 5);
    load(3'b111, 3'b000, 8'h77);
    wait_at(9, 7);
    chk("s3_pend", pendiente, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("s3_xy", {pixel_x, pixel_y}, {10'd0, 10'd0});
    chk("s3_pend", pendiente, 1'b0);
    chk("s3_colors", {ColorP, ColorL, ton}, {3'b000, 3'b111, 8'hFF});
    chk("s3_tick0", pix_tick, 1'b0);
    @(negedge clk);
    chk("s3_tick1", {pix_tick, pixel_x}, {1'b1, 10'd0});
    @(negedge clk);
    chk("s3_adv", {pix_tick, pixel_x}, {1'b0, 10'd1});

    // Sparse random loads; every cycle is checked against the model.
    for (int i = 0; i < 2000; i++) begin
      ColorP_in = 3'($urandom);
      ColorL_in = 3'($urandom);
      ton_in    = 8'($urandom);
      cargar    = ($urandom_range(0, 15) == 0);
      @(negedge clk);
    end
    cargar = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Stop the run if the stimulus never completes.
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/generador_sincronia.md
# generador_sincronia

Generates VGA 640×480@60 Hz timing (hsync, vsync, blank, pixel coordinates) from the 50 MHz system clock. It also holds the frame-synchronous colour configuration (ColorP, ColorL, ton) consumed by the colour output stage. It is the producer side of the pixel-output interface: everything the output stage samples (blank, colour selects, tone byte) originates here. Colour updates requested mid-frame are deferred to the frame boundary to avoid tearing.

## Interface
- DIV, 2, clk cycles per pixel (50 MHz → 25 MHz pixel rate)
- H_VIS, 640; H_FP, 16; H_SYNC, 96; H_BP, 48 — horizontal pixels (total 800)
- V_VIS, 480; V_FP, 10; V_SYNC, 2; V_BP, 33 — vertical lines (total 525)
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- cargar  in  1  one-clk request to load new colour configuration
- ColorP_in  in  3  background colour enables {azul,verde,rojo}
- ColorL_in  in  3  text colour enables {azul,verde,rojo}
- ton_in  in  8  tone byte, [7:6] azul, [5:3] verde, [2:0] rojo
- pix_tick  out  1  one-clk pulse, once every DIV clks
- pixel_x  out  10  current column, 0..799
- pixel_y  out  10  current line, 0..524
- hsync  out  1  active low
- vsync  out  1  active low
- blank  out  1  high outside the visible area
- frame_start  out  1  one-clk pulse on the last pixel of a frame
- ColorP  out  3  applied background enables
- ColorL  out  3  applied text enables
- ton  out  8  applied tone byte
- pendiente  out  1  a loaded configuration awaits the frame boundary

## Operation
- Divider counts 0..DIV-1; pix_tick = (div == DIV-1).
- On a pix_tick clk edge: pixel_x increments, wrapping 799→0. On that wrap, pixel_y increments, wrapping 524→0. No change on other cycles.
- All outputs are registered and coherent with the current pixel_x/pixel_y:
  - blank = (pixel_x ≥ 640) | (pixel_y ≥ 480)
  - hsync = 0 iff 656 ≤ pixel_x ≤ 751
  - vsync = 0 iff 490 ≤ pixel_y ≤ 491
- frame_start = pix_tick & pixel_x==799 & pixel_y==524.
- Configuration path:
  - cargar = 1 captures ColorP_in/ColorL_in/ton_in into shadow registers and sets pendiente.
  - Repeated cargar before the boundary: the latest capture wins.
  - On the frame_start edge, if pendiente was 1 before the edge, the shadow registers copy to ColorP/ColorL/ton and pendiente clears. New colours are therefore valid from pixel (0,0).
- cargar on the same cycle as frame_start: the previous shadow (if pending) is applied, the new values are captured, and pendiente stays 1. The new values apply at the following frame.
- No frame_start while pendiente = 0: the applied colours hold.

## Timing
- Reset values:
  - div = 0, pixel_x = 0, pixel_y = 0, pix_tick = 0
  - hsync = 1, vsync = 1, blank = 0 (pixel (0,0) is visible)
  - frame_start = 0, pendiente = 0
  - ColorP = 3'b000, ColorL = 3'b111, ton = 8'hFF; shadow registers equal the same values
- After reset deasserts, the first pix_tick occurs DIV-1 clks later. The first pixel advance happens on that edge.
- Reset asserted mid-frame aborts the frame: all state returns to the reset values on the next edge, and any pending configuration is discarded.
- Line period = 800·DIV = 1600 clk; frame period = 525 lines = 840 000 clk.
- hsync low for 96·DIV = 192 clk per line; vsync low for 2 lines = 3200 clk.
- Latency:
  - cargar → pendiente: 1 clk.
  - cargar → applied colours: up to one frame, taking effect at the next frame_start edge.

## Test plan
- Free run after reset, counting clks: hsync period 1600 clk with 192 clk low; vsync period 840 000 clk with 3200 clk low; frame_start pulses 840 000 clk apart, each 1 clk wide.
- Blank scan: blank = 0 for exactly 640 pixels per line on lines 0..479, and blank = 1 for all 800 pixels of lines 480..524. Check coherence at x = 639/640 and y = 479/480.
- Sequence: cargar with ColorP_in = 3'b101, ColorL_in = 3'b010, ton_in = 8'hA5 at pixel (100,200); then a second cargar with ton_in = 8'h3C before the boundary. Required: outputs hold reset values and pendiente = 1 until frame_start. At pixel (0,0), outputs read ton = 8'h3C, ColorP = 3'b101, ColorL = 3'b010, and pendiente = 0.
- cargar coincident with frame_start while ton = 8'h11 is already pending: ton becomes 8'h11 at that boundary, the new value applies one frame later, and pendiente stays 1 in between.
- Reset at pixel (300,250) with pendiente = 1: the next clk shows pixel (0,0), pendiente = 0, and colours at their reset values. The first pix_tick follows DIV-1 clks after release.
- Wrap boundary: at pixel (799,524) with pix_tick = 1, check frame_start = 1. The next pixel must be (0,0) with vsync = 1 and blank = 0.
